// File: rtl/sa_ws_input_skew_feeder.sv
// rtl/sa_ws_input_skew_feeder.sv - weight/activation sequencer with diagonal row skew for the WS systolic array
module sa_ws_input_skew_feeder #(
  parameter int NUM_ROW    = 8,
  parameter int NUM_COL    = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ROW*DATA_WIDTH-1:0] s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_is_weight,
  input  logic                          s_last,
  output logic [NUM_ROW*DATA_WIDTH-1:0] o_data,
  output logic [NUM_ROW-1:0]            o_valid,
  output logic [NUM_ROW-1:0]            o_cmd,
  output logic                          o_busy
);

  localparam int WCW = $clog2(NUM_COL + 1);
  localparam int DCW = $clog2(NUM_ROW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]         r_state;
  logic [WCW-1:0]     r_wcnt;
  logic [DCW-1:0]     r_dcnt;
  logic               w_accept;
  logic [NUM_ROW-1:0] w_row_busy;

  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      S_IDLE:   s_ready = 1'b1;
      S_LOAD_W: s_ready = s_is_weight;
      S_STREAM: s_ready = ~s_is_weight;
      default:  s_ready = 1'b0;
    endcase
  end

  assign w_accept = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (s_is_weight) begin
              if (NUM_COL == 1) begin
                r_state <= S_STREAM;
                r_wcnt  <= '0;
              end else begin
                r_state <= S_LOAD_W;
                r_wcnt  <= WCW'(1);
              end
            end else if (s_last) begin
              r_state <= S_DRAIN;
              r_dcnt  <= DCW'(NUM_ROW);
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_LOAD_W: begin
          if (w_accept) begin
            if (r_wcnt == WCW'(NUM_COL - 1)) begin
              r_state <= S_STREAM;
              r_wcnt  <= '0;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
        end
        S_STREAM: begin
          if (w_accept && s_last) begin
            r_state <= S_DRAIN;
            r_dcnt  <= DCW'(NUM_ROW);
          end
        end
        default: begin
          // Hold off new beats until the deepest row has shifted out the tile
          if (r_dcnt == DCW'(1)) begin
            r_state <= S_IDLE;
          end
          r_dcnt <= r_dcnt - DCW'(1);
        end
      endcase
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    logic [DATA_WIDTH-1:0] r_d [0:r];
    logic [r:0]            r_v;
    logic [r:0]            r_c;

    // Row r is a depth r+1 pipe; bubbles enter as all-zero entries
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          r_d[k] <= '0;
        end
        r_v <= '0;
        r_c <= '0;
      end else begin
        r_d[0] <= w_accept ? s_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          r_d[k] <= r_d[k-1];
        end
        r_v <= (r_v << 1) | (r+1)'(w_accept);
        r_c <= (r_c << 1) | (r+1)'(w_accept & s_is_weight);
      end
    end

    assign o_data[r*DATA_WIDTH +: DATA_WIDTH] = r_d[r];
    assign o_valid[r]    = r_v[r];
    assign o_cmd[r]      = r_c[r];
    assign w_row_busy[r] = |r_v;
  end

  assign o_busy = (r_state != S_IDLE) | (|w_row_busy);

endmodule

// File: tb/tb_sa_ws_input_skew_feeder.sv
// tb/tb_sa_ws_input_skew_feeder.sv - self-checking bench for sa_ws_input_skew_feeder
module tb_sa_ws_input_skew_feeder;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [NR*DW-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_is_weight;
  logic              s_last;
  logic [NR*DW-1:0]  o_data;
  logic [NR-1:0]     o_valid;
  logic [NR-1:0]     o_cmd;
  logic              o_busy;

  sa_ws_input_skew_feeder #(.NUM_ROW(NR), .NUM_COL(NC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_is_weight(s_is_weight), .s_last(s_last), .o_data(o_data), .o_valid(o_valid),
    .o_cmd(o_cmd), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] d;
    logic             v;
    logic             c;
  } ent_t;

  // Everything that entered the array front, one entry per clock
  ent_t hist[$];

  // Phase of the tile protocol: 0 idle, 1 loading weights, 2 streaming, 3 draining
  int m_phase;
  int m_weights;
  int m_drain_left;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic w);
    case (m_phase)
      0:       return 1'b1;
      1:       return w;
      2:       return !w;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ent_t hist_at(input int idx);
    ent_t e;
    e.d = '0; e.v = 1'b0; e.c = 1'b0;
    if (idx >= 0 && idx < hist.size()) e = hist[idx];
    return e;
  endfunction

  task automatic check_outputs();
    int   n;
    ent_t e;
    logic busy;
    n = hist.size();
    busy = (m_phase != 0);
    for (int r = 0; r < NR; r++) begin
      e = hist_at(n - 1 - r);
      chk($sformatf("o_valid[%0d]", r), o_valid[r], e.v);
      chk($sformatf("o_cmd[%0d]", r), o_cmd[r], e.c);
      chk($sformatf("o_data[%0d]", r), o_data[r*DW +: DW], e.d[r*DW +: DW]);
      if (hist_at(n - 1 - r).v) busy = 1'b1;
    end
    chk("o_busy", o_busy, busy);
  endtask

  task automatic step(input logic v, input logic w, input logic l,
                      input logic [NR*DW-1:0] d, output logic acc);
    ent_t e;
    logic rdy;
    s_valid = v; s_is_weight = w; s_last = l; s_data = d;
    @(negedge clk);
    rdy = model_ready(w);
    chk("s_ready", s_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    e.d = acc ? d : '0;
    e.v = acc;
    e.c = acc && w;
    hist.push_back(e);
    if (m_phase == 3) begin
      m_drain_left--;
      if (m_drain_left == 0) m_phase = 0;
    end else if (acc) begin
      if (w) begin
        m_weights++;
        if (m_weights == NC) begin
          m_weights = 0;
          m_phase = 2;
        end else begin
          m_phase = 1;
        end
      end else if (l) begin
        m_phase = 3;
        m_drain_left = NR;
      end else begin
        m_phase = 2;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic send(input logic w, input logic l, input logic [NR*DW-1:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 16 && !acc; k++) step(1'b1, w, l, d, acc);
    n_checks++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic idle(input int cycles);
    logic acc;
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, '0, acc);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock
  task automatic do_reset();
    ent_t e;
    s_valid = 1'b0; s_is_weight = 1'b0; s_last = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, '0);
    chk("rst_o_cmd", o_cmd, '0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_busy", o_busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    hist.delete();
    m_phase = 0; m_weights = 0; m_drain_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    e.d = '0; e.v = 1'b0; e.c = 1'b0;
    hist.push_back(e);
    #1;
    check_outputs();
  endtask

  initial begin
    logic             acc;
    logic [NR*DW-1:0] base;
    logic             pend, pw, pl;
    logic [NR*DW-1:0] pd;
    int               stall;
    n_checks = 0; n_fail = 0;
    m_phase = 0; m_weights = 0; m_drain_left = 0;
    rst_n = 1'b1; s_valid = 1'b0; s_is_weight = 1'b0; s_last = 1'b0; s_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    base = 32'h04030201;
    for (int i = 0; i < NC; i++) send(1'b1, 1'b0, base + 32'(i) * 32'h04040404);

    send(1'b0, 1'b0, $urandom);
    idle(1);
    send(1'b0, 1'b0, $urandom);
    send(1'b0, 1'b1, $urandom);

    send(1'b1, 1'b0, $urandom);
    send(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, acc);
    step(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, acc);
    send(1'b1, 1'b0, $urandom);
    send(1'b1, 1'b0, $urandom);
    send(1'b0, 1'b1, 32'hA5A5A5A5);
    idle(NR + 2);

    send(1'b1, 1'b0, $urandom);
    send(1'b1, 1'b0, $urandom);
    do_reset();
    for (int i = 0; i < NC - 1; i++) send(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, acc);
    send(1'b1, 1'b0, $urandom);
    send(1'b0, 1'b1, 32'h5A5A5A5A);
    idle(NR + 2);

    pend = 1'b0; pw = 1'b0; pl = 1'b0; pd = '0; stall = 0;
    for (int c = 0; c < 300; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pw = ($urandom_range(0, 2) == 0);
        pl = ($urandom_range(0, 3) == 0);
        pd = $urandom;
        stall = 0;
      end
      step(pend, pw, pl, pd, acc);
      if (acc) pend = 1'b0;
      else if (pend) begin
        stall++;
        if (stall > 8) pend = 1'b0;
      end
    end
    idle(NR + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_ws_input_skew_feeder.md
Name: sa_ws_input_skew_feeder

Overview:
Upstream feeder for the weight-stationary systolic array datapath. It accepts whole row-vectors over a valid/ready stream and sequences a weight-load phase followed by an activation phase. It applies the diagonal skew: row r is delayed r extra cycles. It drives the array's per-row data, valid and cmd inputs so that the wavefront enters the PE grid correctly.

Parameters:
NUM_ROW, 8, number of array rows (lanes in each vector)
NUM_COL, 8, number of array columns (weight beats per load)
DATA_WIDTH, 8, width of one lane element

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
s_data  input  NUM_ROW*DATA_WIDTH  input vector; lane r at [r*DATA_WIDTH+:DATA_WIDTH]
s_valid  input  1  input beat valid
s_ready  output  1  feeder can accept the beat
s_is_weight  input  1  1 = weight beat, 0 = activation beat
s_last  input  1  last activation beat of a tile (ignored on weight beats)
o_data  output  NUM_ROW*DATA_WIDTH  skewed data to array i_data
o_valid  output  NUM_ROW  skewed per-row valid to array i_valid
o_cmd  output  NUM_ROW  skewed per-row cmd (1 = weight shift-in) to array i_cmd
o_busy  output  1  FSM not in IDLE, or any skew stage holds valid

Behaviour:
- One clock, clk. Reset is asynchronous active-low on rst_n and clears all state.
- Reset values: o_data=0, o_valid=0, o_cmd=0, o_busy=0, FSM=IDLE, weight counter=0, s_ready combinational per the state rules below.
- Accept occurs when s_valid && s_ready on a rising clk edge.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
  - IDLE: s_ready=1 for any beat.
    - Accepted weight beat: wcnt=1, go to LOAD_W. If NUM_COL==1, go to STREAM instead.
    - Accepted activation beat: go to STREAM. This reuses the loaded weights. If s_last is also set, go to DRAIN.
  - LOAD_W: s_ready = s_is_weight.
    - An activation beat is stalled (not dropped).
    - Each accepted beat increments wcnt. The beat that makes wcnt==NUM_COL moves to STREAM and clears wcnt.
  - STREAM: s_ready = ~s_is_weight.
    - A weight beat is stalled until the tile ends.
    - An accepted beat with s_last=1 moves to DRAIN and loads dcnt=NUM_ROW.
  - DRAIN: s_ready=0. dcnt decrements each cycle; at dcnt==1 go to IDLE. This guarantees the skew pipe is empty before new weights enter.
- Stage-0 entry every cycle:
  - On accept: {data, valid=1, cmd=s_is_weight}.
  - Otherwise a bubble: {0, valid=0, cmd=0}. Dummy data is always zero.
- Skew: row r output = row-r lane of the stage-0 entry delayed r+1 cycles.
  - Latency from accept edge: row 0 appears 1 cycle later, row NUM_ROW-1 appears NUM_ROW cycles later.
  - Implemented as per-row shift registers of depth r+1 carrying data, valid and cmd together.
- data, valid and cmd of one beat always stay aligned on a given row. Only the row-to-row offset differs.
- Weight and activation beats may be back-to-back (LOAD_W→STREAM): no gap is inserted.
- Reset mid-operation: all skew stages are flushed to zero immediately (asynchronous). A partially loaded weight set is discarded, wcnt=0, FSM=IDLE.
- s_data, s_is_weight and s_last are sampled only on accept. The upstream source must hold a stalled beat stable.
- o_busy is combinational from state and the OR of all skew-stage valid bits.

Test Plan:
- NUM_ROW=NUM_COL=4, DATA_WIDTH=8. Assert and release rst_n → o_valid=4'b0, o_cmd=4'b0, o_data=0, o_busy=0, s_ready=1.
- Four weight beats back-to-back, s_data={8'h04,8'h03,8'h02,8'h01} plus increments → o_cmd[r]=1 and o_valid[r]=1 for exactly 4 consecutive cycles starting r+1 cycles after the first accept; FSM in STREAM after the 4th beat.
- Activation presented during LOAD_W after 2 weights → s_ready=0 until 2 more weights are accepted; the activation is then accepted and appears on row 0 with o_cmd[0]=0.
- Activation tile of 3 beats, s_valid low for 1 cycle between beats 1 and 2 → bubble of valid=0 and data=0 appears on every row at offset r+1; the s_last beat triggers DRAIN; s_ready=0 for 4 cycles; o_busy falls when o_valid[3] of the last beat clears.
- Weight beat presented in STREAM → stalled until DRAIN completes, then accepted in IDLE; wcnt restarts at 1.
- rst_n pulsed low while beats are in the skew pipe and wcnt=2 → o_valid=0 within the same cycle (asynchronous); after release FSM=IDLE; a full 4-beat reload is required before reaching STREAM.
